// File: rtl/car_step_controller.sv
// car_step_controller: per-frame collision handshake initiator owning car position and velocity.
module car_step_controller #(
  parameter int POSITION_SIZE = 8,
  parameter int GRAVITY = 1,
  parameter int MAX_SPEED = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_in,
  input  logic                     init_valid_in,
  input  logic [POSITION_SIZE-1:0] init_x_in,
  input  logic [POSITION_SIZE-1:0] init_y_in,
  input  logic [POSITION_SIZE-1:0] init_dx_in,
  input  logic [POSITION_SIZE-1:0] init_dy_in,
  output logic                     begin_out,
  output logic [POSITION_SIZE-1:0] pos_x_out,
  output logic [POSITION_SIZE-1:0] pos_y_out,
  output logic [POSITION_SIZE-1:0] dx_out,
  output logic [POSITION_SIZE-1:0] dy_out,
  input  logic                     result_in,
  input  logic [POSITION_SIZE-1:0] x_new_in,
  input  logic [POSITION_SIZE-1:0] y_new_in,
  output logic [POSITION_SIZE-1:0] car_x_out,
  output logic [POSITION_SIZE-1:0] car_y_out,
  output logic [POSITION_SIZE-1:0] car_dx_out,
  output logic [POSITION_SIZE-1:0] car_dy_out,
  output logic                     busy_out,
  output logic                     step_done_out,
  output logic                     timeout_out,
  output logic                     frame_miss_out,
  output logic [15:0]              step_count_out
);
  localparam int P = POSITION_SIZE;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [P:0] SMAX = (P+1)'(MAX_SPEED);
  localparam logic signed [P:0] NMAX = -SMAX;
  localparam logic signed [P:0] GRAV = (P+1)'(GRAVITY);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, UPDATE} state_t;
  state_t r_state;
  logic [P-1:0] r_pos_x, r_pos_y, r_dx, r_dy;
  logic [P-1:0] r_car_x, r_car_y, r_car_dx, r_car_dy;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_count;
  logic r_begin, r_busy, r_done, r_timeout, r_miss, r_res_d;
  logic w_accept;
  logic signed [P:0] w_dy_sum;
  logic [P-1:0] w_dy_next;
  // Gravity is added one bit wider so the clamp sees the true sum before wrap.
  assign w_dy_sum = $signed({r_car_dy[P-1], r_car_dy}) + GRAV;
  assign w_dy_next = w_dy_sum > SMAX ? SMAX[P-1:0] : w_dy_sum < NMAX ? NMAX[P-1:0] : w_dy_sum[P-1:0];
  assign w_accept = (r_state == WAIT) && result_in && !r_res_d;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      {r_pos_x, r_pos_y, r_dx, r_dy} <= '0;
      {r_car_x, r_car_y, r_car_dx, r_car_dy} <= '0;
      r_cnt <= '0;
      r_count <= '0;
      {r_begin, r_busy, r_done, r_timeout, r_miss, r_res_d} <= '0;
    end else begin
      r_res_d <= result_in;
      r_done <= 1'b0;
      r_timeout <= 1'b0;
      r_miss <= 1'b0;
      if (init_valid_in) begin
        {r_car_x, r_car_y, r_car_dx, r_car_dy} <= {init_x_in, init_y_in, init_dx_in, init_dy_in};
        r_begin <= 1'b0;
        r_busy <= 1'b0;
        r_state <= IDLE;
      end else begin
        r_miss <= frame_in && r_state != IDLE;
        case (r_state)
          IDLE: if (frame_in) begin
            {r_pos_x, r_pos_y, r_dx, r_dy} <= {r_car_x, r_car_y, r_car_dx, r_car_dy};
            r_begin <= 1'b1;
            r_busy <= 1'b1;
            r_state <= LAUNCH;
          end
          LAUNCH: begin
            r_begin <= 1'b0;
            r_cnt <= '0;
            r_state <= WAIT;
          end
          WAIT: if (w_accept) begin
            r_car_x <= x_new_in;
            r_car_y <= y_new_in;
            r_state <= UPDATE;
          end else if (r_cnt == LAST) begin
            r_timeout <= 1'b1;
            r_busy <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          UPDATE: begin
            r_car_dy <= w_dy_next;
            r_done <= 1'b1;
            r_count <= r_count + 16'd1;
            r_busy <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign begin_out = r_begin;
  assign pos_x_out = r_pos_x;
  assign pos_y_out = r_pos_y;
  assign dx_out = r_dx;
  assign dy_out = r_dy;
  assign car_x_out = r_car_x;
  assign car_y_out = r_car_y;
  assign car_dx_out = r_car_dx;
  assign car_dy_out = r_car_dy;
  assign busy_out = r_busy;
  assign step_done_out = r_done;
  assign timeout_out = r_timeout;
  assign frame_miss_out = r_miss;
  assign step_count_out = r_count;
endmodule

// File: tb/tb_car_step_controller.sv
// tb_car_step_controller: directed table, corner sequences and random stimulus against a cycle model.
module tb_car_step_controller;
  localparam int TC = 8;
  localparam int GRAV = 1;
  localparam int MAXS = 16;
  logic clk = 1'b0;
  logic rst = 1'b0, ini = 1'b0, frm = 1'b0, res = 1'b0;
  logic [7:0] ix = '0, iy = '0, idx = '0, idy = '0, xn = '0, yn = '0;
  logic begin_o, busy_o, done_o, tmo_o, miss_o;
  logic [7:0] px, py, pdx, pdy, cx, cy, cdx, cdy;
  logic [15:0] cnt_o;
  int n_chk = 0, n_pass = 0;
  car_step_controller #(.POSITION_SIZE(8), .GRAVITY(GRAV), .MAX_SPEED(MAXS), .TIMEOUT_CYCLES(TC)) dut (
    .clk_in(clk), .rst_in(rst), .frame_in(frm), .init_valid_in(ini),
    .init_x_in(ix), .init_y_in(iy), .init_dx_in(idx), .init_dy_in(idy),
    .begin_out(begin_o), .pos_x_out(px), .pos_y_out(py), .dx_out(pdx), .dy_out(pdy),
    .result_in(res), .x_new_in(xn), .y_new_in(yn),
    .car_x_out(cx), .car_y_out(cy), .car_dx_out(cdx), .car_dy_out(cdy),
    .busy_out(busy_o), .step_done_out(done_o), .timeout_out(tmo_o),
    .frame_miss_out(miss_o), .step_count_out(cnt_o)
  );
  always #5 clk = ~clk;
  // Model: m_age 0 = idle, 1 = launch cycle, >=2 = waiting (wait index age-2), -1 = commit pending.
  logic m_ok = 1'b0, m_prev = 1'b0;
  logic m_beg, m_busy, m_done, m_tmo, m_miss;
  logic [7:0] m_px, m_py, m_pdx, m_pdy, m_cx, m_cy, m_cdx, m_cdy;
  logic [15:0] m_cnt;
  int m_age = 0;
  task automatic model_step();
    logic rise;
    int d;
    rise = res && !m_prev;
    m_prev = res;
    {m_done, m_tmo, m_miss} = '0;
    if (rst) begin
      {m_beg, m_busy, m_prev} = '0;
      {m_px, m_py, m_pdx, m_pdy, m_cx, m_cy, m_cdx, m_cdy} = '0;
      m_cnt = '0;
      m_age = 0;
      m_ok = 1'b1;
    end else if (ini) begin
      {m_cx, m_cy, m_cdx, m_cdy} = {ix, iy, idx, idy};
      {m_beg, m_busy} = '0;
      m_age = 0;
    end else begin
      m_miss = frm && m_age != 0;
      if (m_age == 0) begin
        if (frm) begin
          {m_px, m_py, m_pdx, m_pdy} = {m_cx, m_cy, m_cdx, m_cdy};
          {m_beg, m_busy} = 2'b11;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        m_beg = 1'b0;
        m_age = 2;
      end else if (m_age < 0) begin
        d = int'($signed(m_cdy)) + GRAV;
        d = d > MAXS ? MAXS : d < -MAXS ? -MAXS : d;
        m_cdy = 8'(d);
        m_done = 1'b1;
        m_cnt = m_cnt + 16'd1;
        m_busy = 1'b0;
        m_age = 0;
      end else if (rise) begin
        m_cx = xn;
        m_cy = yn;
        m_age = -1;
      end else if (m_age - 2 == TC - 1) begin
        m_tmo = 1'b1;
        m_busy = 1'b0;
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask
  function automatic logic [84:0] dut_all();
    return {begin_o, busy_o, done_o, tmo_o, miss_o, px, py, pdx, pdy, cx, cy, cdx, cdy, cnt_o};
  endfunction
  function automatic logic [84:0] model_all();
    return {m_beg, m_busy, m_done, m_tmo, m_miss, m_px, m_py, m_pdx, m_pdy, m_cx, m_cy, m_cdx, m_cdy, m_cnt};
  endfunction
  task automatic chk(input string name, input logic [84:0] act, input logic [84:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_ok) chk("model", dut_all(), model_all());
  endtask
  typedef struct {
    logic rst, ini, frm, res;
    logic [7:0] ix, iy, idx, idy, xn, yn;
    logic e_beg, e_busy, e_done, e_tmo, e_miss;
    logic [7:0] e_x, e_y, e_dy;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tv[22];
  initial begin
    tv[0]  = '{1,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0, 0};
    tv[1]  = '{0,1,0,0, 10,20,2,0, 0,0, 0,0,0,0,0, 10,20,0, 0};
    tv[2]  = '{0,0,1,0, 0,0,0,0, 0,0, 1,1,0,0,0, 10,20,0, 0};
    tv[3]  = '{0,0,0,0, 0,0,0,0, 0,0, 0,1,0,0,0, 10,20,0, 0};
    tv[4]  = '{0,0,0,0, 0,0,0,0, 0,0, 0,1,0,0,0, 10,20,0, 0};
    tv[5]  = '{0,0,0,1, 0,0,0,0, 12,20, 0,1,0,0,0, 12,20,0, 0};
    tv[6]  = '{0,0,0,1, 0,0,0,0, 12,20, 0,0,1,0,0, 12,20,1, 1};
    tv[7]  = '{0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 12,20,1, 1};
    tv[8]  = '{0,1,0,0, 10,20,2,15, 0,0, 0,0,0,0,0, 10,20,15, 1};
    tv[9]  = '{0,0,1,0, 0,0,0,0, 0,0, 1,1,0,0,0, 10,20,15, 1};
    tv[10] = '{0,0,1,0, 0,0,0,0, 0,0, 0,1,0,0,1, 10,20,15, 1};
    tv[11] = '{0,0,0,1, 0,0,0,0, 11,21, 0,1,0,0,0, 11,21,15, 1};
    tv[12] = '{0,0,1,1, 0,0,0,0, 11,21, 0,0,1,0,1, 11,21,16, 2};
    tv[13] = '{0,0,1,0, 0,0,0,0, 0,0, 1,1,0,0,0, 11,21,16, 2};
    tv[14] = '{0,0,0,0, 0,0,0,0, 0,0, 0,1,0,0,0, 11,21,16, 2};
    tv[15] = '{0,0,0,1, 0,0,0,0, 12,22, 0,1,0,0,0, 12,22,16, 2};
    tv[16] = '{0,0,0,0, 0,0,0,0, 0,0, 0,0,1,0,0, 12,22,16, 3};
    tv[17] = '{0,1,1,0, 10,20,2,253, 0,0, 0,0,0,0,0, 10,20,253, 3};
    tv[18] = '{0,0,1,0, 0,0,0,0, 0,0, 1,1,0,0,0, 10,20,253, 3};
    tv[19] = '{0,0,0,0, 0,0,0,0, 0,0, 0,1,0,0,0, 10,20,253, 3};
    tv[20] = '{0,0,0,1, 0,0,0,0, 5,6, 0,1,0,0,0, 5,6,253, 3};
    tv[21] = '{0,0,0,1, 0,0,0,0, 5,6, 0,0,1,0,0, 5,6,254, 4};
    for (int i = 0; i < 22; i++) begin
      {rst, ini, frm, res} = {tv[i].rst, tv[i].ini, tv[i].frm, tv[i].res};
      {ix, iy, idx, idy, xn, yn} = {tv[i].ix, tv[i].iy, tv[i].idx, tv[i].idy, tv[i].xn, tv[i].yn};
      tick();
      chk($sformatf("row%0d", i), 85'({begin_o, busy_o, done_o, tmo_o, miss_o, cx, cy, cdy, cnt_o}),
          85'({tv[i].e_beg, tv[i].e_busy, tv[i].e_done, tv[i].e_tmo, tv[i].e_miss, tv[i].e_x, tv[i].e_y, tv[i].e_dy, tv[i].e_cnt}));
    end
    {rst, ini, frm, res} = '0;
    tick();
    frm = 1'b1;
    tick();
    frm = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("timeout_k%0d", k), 85'({tmo_o, busy_o}), 85'({k == 9, k < 9}));
    end
    tick();
    chk("after_timeout", 85'({tmo_o, busy_o, cx, cy, cdy, cnt_o}), 85'({2'b00, 8'd5, 8'd6, 8'hFE, 16'd4}));
    res = 1'b1;
    xn = 8'd33;
    yn = 8'd44;
    tick();
    frm = 1'b1;
    tick();
    frm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("held_k%0d", k), 85'({cx, done_o}), 85'({8'd5, 1'b0}));
    end
    res = 1'b0;
    tick();
    res = 1'b1;
    tick();
    chk("fresh_edge_pos", 85'({cx, cy}), 85'({8'd33, 8'd44}));
    tick();
    chk("fresh_edge_done", 85'({done_o, cnt_o}), 85'({1'b1, 16'd5}));
    res = 1'b0;
    frm = 1'b1;
    tick();
    frm = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_in_wait", dut_all(), 85'd0);
    rst = 1'b0;
    res = 1'b1;
    tick();
    tick();
    chk("late_result", 85'({busy_o, done_o, cx, cnt_o}), 85'd0);
    res = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 300) == 0;
      ini = ($urandom % 40) == 0;
      frm = ($urandom % 5) == 0;
      if (($urandom % 3) == 0) res = ~res;
      {ix, iy, idx, idy} = 32'($urandom);
      {xn, yn} = 16'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
